// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline: stall-vector layout,
// the canonical NOP payload and the per-cycle pipeline-register action.
package core_pipe_pkg;

    // Bit positions of each stage in the core-wide stall vector
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int STG_CTL = 5;

    localparam int STALL_W = 6;

    // An all-zero instruction word decodes as NOP downstream
    localparam logic [31:0] NOP_WORD = 32'h0;

    // Action taken by an inter-stage register in a given cycle, in priority order
    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } pipe_act_e;

endpackage : core_pipe_pkg

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment unless already at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries pc, payload, valid and a sticky exception flag, obeys the core
// stall vector plus a redirect flush, and counts hold/bubble/flush events.
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STAGE        = 1,
    parameter int STALL_W      = core_pipe_pkg::STALL_W,
    parameter int CNT_W        = 16,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [31:0]        in_pc,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_exc,
    output logic               out_valid,
    output logic [31:0]        out_pc,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_exc,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // Counter slots in the instance array
    localparam int CNT_HOLD   = 0;
    localparam int CNT_BUBBLE = 1;
    localparam int CNT_FLUSH  = 2;
    localparam int CNT_NUM    = 3;

    // Payload written on flush/bubble so the downstream decoder sees a NOP
    localparam logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_WORD);

    // Reject configurations where STAGE+1 falls outside the stall vector
    if ((STAGE < 0) || (STAGE > STALL_W - 2) || (DATA_W < 1)) begin : g_bad_cfg
        $fatal(1, "pipe_stage_reg: illegal STAGE/STALL_W/DATA_W combination");
    end

    // Only our own stage bit and the downstream stage bit matter
    logic stall_up;
    logic stall_dn;
    assign stall_up = stall[STAGE];
    assign stall_dn = stall[STAGE+1];

    logic unused_stall_bits;
    assign unused_stall_bits = ^stall;

    pipe_act_e act;

    logic              valid_q, valid_d;
    logic [31:0]       pc_q,    pc_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              exc_q,   exc_d;

    logic [CNT_NUM-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [CNT_NUM];

    // Action decode: flush beats bubble beats advance beats hold
    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall_up && !stall_dn) begin
            act = ACT_BUBBLE;
        end else if (!stall_up) begin
            act = ACT_ADVANCE;
        end else begin
            act = ACT_HOLD;
        end
    end

    // Next register contents for the chosen action
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        unique case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                pc_d    = '0;
                data_d  = NOP_DATA;
                exc_d   = 1'b0;
            end
            ACT_ADVANCE: begin
                valid_d = in_valid;
                pc_d    = in_pc;
                data_d  = in_data;
                exc_d   = in_exc & in_valid;
                // Scrub stale fields so invalid slots never leak old data
                if (!in_valid && ZERO_INVALID) begin
                    pc_d   = '0;
                    data_d = '0;
                    exc_d  = 1'b0;
                end
            end
            default: begin
                // ACT_HOLD keeps every field
            end
        endcase
    end

    // Stage register; reset overrides stall and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_data  = data_q;
    assign out_exc   = exc_q;

    // Event strobes; a flush only counts if it actually threw away a valid entry
    always_comb begin
        cnt_inc             = '0;
        cnt_inc[CNT_HOLD]   = (act == ACT_HOLD);
        cnt_inc[CNT_BUBBLE] = (act == ACT_BUBBLE);
        cnt_inc[CNT_FLUSH]  = (act == ACT_FLUSH) &&
                              (valid_q || (!stall_up && in_valid));
    end

    for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (cnt_inc[gi]),
            .cnt (cnt_val[gi])
        );
    end

    assign hold_cnt   = cnt_val[CNT_HOLD];
    assign bubble_cnt = cnt_val[CNT_BUBBLE];
    assign flush_cnt  = cnt_val[CNT_FLUSH];

    // A stalled downstream stage with a running upstream stage is a controller bug
    a_legal_stall : assert property (
        @(posedge clk) disable iff (rst) !(!stall_up && stall_dn)
    );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (STAGE=1, CNT_W=2, ZERO_INVALID=1).
module tb_pipe_stage_reg;

    localparam int DATA_W  = 32;
    localparam int STALL_W = 6;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [31:0]        in_pc;
    logic [DATA_W-1:0]  in_data;
    logic               in_exc;
    logic               out_valid;
    logic [31:0]        out_pc;
    logic [DATA_W-1:0]  out_data;
    logic               out_exc;
    logic               cnt_clr;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .DATA_W       (DATA_W),
        .STAGE        (1),
        .STALL_W      (STALL_W),
        .CNT_W        (CNT_W),
        .ZERO_INVALID (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_data    (in_data),
        .in_exc     (in_exc),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_data   (out_data),
        .out_exc    (out_exc),
        .cnt_clr    (cnt_clr),
        .hold_cnt   (hold_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic report(input string what);
        $display("step %-28s valid=%0b pc=%h data=%h exc=%0b hold=%0d bubble=%0d flush=%0d",
                 what, out_valid, out_pc, out_data, out_exc, hold_cnt, bubble_cnt, flush_cnt);
    endtask

    initial begin
        rst      = 1'b1;
        stall    = '0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_pc    = 32'h100;
        in_data  = 32'h1234_5678;
        in_exc   = 1'b0;
        cnt_clr  = 1'b0;

        // Reset held for two cycles with a valid entry on the input
        tick(); tick();
        report("reset");
        chk("rst_valid",  32'(out_valid),  32'h0);
        chk("rst_pc",     out_pc,          32'h0);
        chk("rst_hold",   32'(hold_cnt),   32'h0);
        chk("rst_bubble", 32'(bubble_cnt), 32'h0);
        chk("rst_flush",  32'(flush_cnt),  32'h0);

        // Plain advance
        rst     = 1'b0;
        in_pc   = 32'h1000;
        in_data = 32'h8C22_0004;
        tick();
        report("advance");
        chk("adv_valid", 32'(out_valid), 32'h1);
        chk("adv_pc",    out_pc,         32'h1000);
        chk("adv_data",  out_data,       32'h8C22_0004);

        // Bubble: own stage stalled, downstream free
        stall = 6'b000010;
        tick();
        report("bubble");
        chk("bub_valid", 32'(out_valid),  32'h0);
        chk("bub_pc",    out_pc,          32'h0);
        chk("bub_data",  out_data,        32'h0);
        chk("bub_cnt",   32'(bubble_cnt), 32'h1);

        // Advance an entry carrying an exception, then hold it for 3 cycles
        stall   = 6'b000000;
        in_pc   = 32'h1004;
        in_data = 32'h0043_0820;
        in_exc  = 1'b1;
        tick();
        report("advance_exc");
        chk("adv2_exc", 32'(out_exc), 32'h1);

        stall   = 6'b000110;
        in_pc   = 32'h5555_0000;
        in_data = 32'hFFFF_FFFF;
        in_exc  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            report("hold");
        end
        chk("hold_valid", 32'(out_valid), 32'h1);
        chk("hold_pc",    out_pc,         32'h1004);
        chk("hold_data",  out_data,       32'h0043_0820);
        chk("hold_exc",   32'(out_exc),   32'h1);
        chk("hold_cnt",   32'(hold_cnt),  32'h3);

        // Flush beats a hold and discards a valid entry
        flush = 1'b1;
        tick();
        report("flush_valid");
        chk("fl_valid", 32'(out_valid), 32'h0);
        chk("fl_pc",    out_pc,         32'h0);
        chk("fl_exc",   32'(out_exc),   32'h0);
        chk("fl_cnt",   32'(flush_cnt), 32'h1);
        chk("fl_hold",  32'(hold_cnt),  32'h3);

        // Flush with nothing valid anywhere is not counted
        in_valid = 1'b0;
        tick();
        report("flush_empty");
        chk("fl_empty_cnt", 32'(flush_cnt), 32'h1);

        // Flush that kills an advancing valid input is counted
        stall    = 6'b000000;
        in_valid = 1'b1;
        tick();
        report("flush_incoming");
        chk("fl_in_cnt",   32'(flush_cnt), 32'h2);
        chk("fl_in_valid", 32'(out_valid), 32'h0);

        // Bubble counter saturates at 3 with CNT_W=2
        flush = 1'b0;
        stall = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            tick();
            report("bubble_sat");
        end
        chk("sat_bubble", 32'(bubble_cnt), 32'h3);

        // Clear wins over a same-cycle bubble increment
        cnt_clr = 1'b1;
        tick();
        report("clear");
        cnt_clr = 1'b0;
        chk("clr_bubble", 32'(bubble_cnt), 32'h0);
        chk("clr_hold",   32'(hold_cnt),   32'h0);
        chk("clr_flush",  32'(flush_cnt),  32'h0);

        // Invalid advance scrubs pc/data/exc
        stall    = 6'b000000;
        in_valid = 1'b0;
        in_pc    = 32'h2000;
        in_data  = 32'hDEAD_BEEF;
        in_exc   = 1'b1;
        tick();
        report("invalid_advance");
        chk("inv_valid", 32'(out_valid), 32'h0);
        chk("inv_pc",    out_pc,         32'h0);
        chk("inv_data",  out_data,       32'h0);
        chk("inv_exc",   32'(out_exc),   32'h0);

        // Unrelated stall bits do not block an advance
        stall    = 6'b111001;
        in_valid = 1'b1;
        in_pc    = 32'h3000;
        in_data  = 32'h0000_0013;
        in_exc   = 1'b0;
        tick();
        report("advance_other_bits");
        chk("oth_valid", 32'(out_valid), 32'h1);
        chk("oth_pc",    out_pc,         32'h3000);

        // Reset in the middle of a hold sequence clears everything
        stall = 6'b000110;
        tick(); tick();
        report("hold_before_rst");
        chk("prerst_hold", 32'(hold_cnt), 32'h2);
        chk("prerst_pc",   out_pc,        32'h3000);
        rst = 1'b1;
        tick();
        report("rst_mid_hold");
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_pc",    out_pc,         32'h0);
        chk("midrst_data",  out_data,       32'h0);
        chk("midrst_hold",  32'(hold_cnt),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg
